// File: rtl/fp_capture_ctrl.sv
// fp_capture_ctrl
// Captures a 1-bit microphone stream and builds a run-length histogram in an
// external single-port RAM. The RAM has a registered read. After capture it
// streams every bin out over a valid/ready interface.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, abort      : session request (ignored while busy), forced return to IDLE
//   capture_len       : number of accepted sample ticks per capture (latched on start)
//   sample_tick       : one-cycle strobe qualifying mic_bit
//   mic_bit           : microphone sample
//   hist_addr         : histogram RAM address
//   hist_rd_en        : histogram RAM read strobe
//   hist_wr_en        : histogram RAM write strobe
//   hist_wr_data      : histogram RAM write data
//   hist_rd_data      : RAM read data, valid one cycle after hist_rd_en
//   out_valid         : readout stream valid
//   out_data          : readout stream data
//   out_last          : readout stream last-beat flag
//   out_ready         : readout stream back-pressure
//   busy, done        : busy flag and session-complete pulse
//   overrun_err       : sticky error flag for ticks that were dropped
module fp_capture_ctrl #(
  parameter int NUM_BINS = 50,
  parameter int BIN_W    = 20,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [19:0]       capture_len,
  input  logic              sample_tick,
  input  logic              mic_bit,
  output logic [ADDR_W-1:0] hist_addr,
  output logic              hist_rd_en,
  output logic              hist_wr_en,
  output logic [BIN_W-1:0]  hist_wr_data,
  input  logic [BIN_W-1:0]  hist_rd_data,
  output logic              out_valid,
  output logic [BIN_W-1:0]  out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_CAPTURE, S_READ, S_EMIT, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NUM_BINS - 1);
  localparam logic [BIN_W-1:0]  BIN_MAX  = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   k_q, k_d;               // clear address, then readout bin index
  logic [ADDR_W-1:0]   run_cnt_q, run_cnt_d;
  logic                rmw_q, rmw_d;           // RMW write cycle pending
  logic [ADDR_W-1:0]   rmw_addr_q, rmw_addr_d;
  logic [19:0]         rem_q, rem_d;           // remaining ticks to accept
  logic                overrun_q, overrun_d;
  logic                emit_first_q, emit_first_d;
  logic [BIN_W-1:0]    out_data_q, out_data_d;

  // Ticks only count in CAPTURE while ticks remain; a tick landing on the
  // RMW write cycle cannot start a new read and is dropped.
  logic tick_live, tick_acc, tick_drop, rmw_start;
  assign tick_live = (state_q == S_CAPTURE) && sample_tick && (rem_q != '0);
  assign tick_drop = tick_live && rmw_q;
  assign tick_acc  = tick_live && !rmw_q;
  assign rmw_start = tick_acc && !mic_bit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (start) state_d = S_CLEAR;
        // Zero-length capture goes straight to readout.
        S_CLEAR:   if (k_q == LAST_BIN) state_d = (rem_q == '0) ? S_READ : S_CAPTURE;
        // rem_q reaches zero one cycle after the final tick, which is exactly
        // the write cycle of any RMW that tick started, so the write lands here.
        S_CAPTURE: if (rem_q == '0) state_d = S_READ;
        S_READ:    state_d = S_EMIT;
        S_EMIT:    if (out_ready) state_d = (k_q == LAST_BIN) ? S_DONE : S_READ;
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next-state
  always_comb begin
    k_d          = k_q;
    run_cnt_d    = run_cnt_q;
    rmw_d        = 1'b0;
    rmw_addr_d   = rmw_addr_q;
    rem_d        = rem_q;
    overrun_d    = overrun_q;
    emit_first_d = 1'b0;
    out_data_d   = out_data_q;
    if (abort) begin
      k_d       = '0;
      run_cnt_d = '0;
      rem_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            k_d       = '0;
            run_cnt_d = '0;
            rem_d     = capture_len;
            overrun_d = 1'b0;
          end
        end
        S_CLEAR: k_d = (k_q == LAST_BIN) ? '0 : k_q + 1'b1;
        S_CAPTURE: begin
          if (tick_drop) overrun_d = 1'b1;
          if (tick_acc) begin
            rem_d = rem_q - 20'd1;
            if (mic_bit) begin
              if (run_cnt_q != LAST_BIN) run_cnt_d = run_cnt_q + 1'b1;
            end else begin
              rmw_d      = 1'b1;
              rmw_addr_d = run_cnt_q;
              run_cnt_d  = '0;
            end
          end
        end
        S_READ: emit_first_d = 1'b1;
        S_EMIT: begin
          // RAM data is only guaranteed on the first EMIT cycle; hold a copy.
          if (emit_first_q) out_data_d = hist_rd_data;
          if (out_ready) k_d = (k_q == LAST_BIN) ? '0 : k_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q          <= '0;
      run_cnt_q    <= '0;
      rmw_q        <= 1'b0;
      rmw_addr_q   <= '0;
      rem_q        <= '0;
      overrun_q    <= 1'b0;
      emit_first_q <= 1'b0;
      out_data_q   <= '0;
    end else begin
      k_q          <= k_d;
      run_cnt_q    <= run_cnt_d;
      rmw_q        <= rmw_d;
      rmw_addr_q   <= rmw_addr_d;
      rem_q        <= rem_d;
      overrun_q    <= overrun_d;
      emit_first_q <= emit_first_d;
      out_data_q   <= out_data_d;
    end
  end

  // Outputs. RAM strobes are suppressed in an abort cycle so nothing is
  // written once abort is seen.
  always_comb begin
    hist_addr    = '0;
    hist_rd_en   = 1'b0;
    hist_wr_en   = 1'b0;
    hist_wr_data = '0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_last     = 1'b0;
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    overrun_err  = overrun_q;
    case (state_q)
      S_CLEAR: begin
        hist_wr_en = !abort;
        hist_addr  = k_q;
      end
      S_CAPTURE: begin
        if (rmw_q) begin
          hist_wr_en   = !abort;
          hist_addr    = rmw_addr_q;
          hist_wr_data = (hist_rd_data == BIN_MAX) ? BIN_MAX : hist_rd_data + 1'b1;
        end else if (rmw_start) begin
          hist_rd_en = !abort;
          hist_addr  = run_cnt_q;
        end
      end
      S_READ: begin
        hist_rd_en = !abort;
        hist_addr  = k_q;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        out_data  = emit_first_q ? hist_rd_data : out_data_q;
        out_last  = (k_q == LAST_BIN);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fp_capture_ctrl.sv
module tb_fp_capture_ctrl;
  localparam int NUM_BINS = 50;
  localparam int BIN_W    = 20;
  localparam int ADDR_W   = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [19:0]       capture_len = '0;
  logic              sample_tick = 1'b0;
  logic              mic_bit = 1'b0;
  logic [ADDR_W-1:0] hist_addr;
  logic              hist_rd_en, hist_wr_en;
  logic [BIN_W-1:0]  hist_wr_data;
  logic [BIN_W-1:0]  hist_rd_data = '0;
  logic              out_valid;
  logic [BIN_W-1:0]  out_data;
  logic              out_last;
  logic              out_ready = 1'b0;
  logic              busy, done, overrun_err;

  always #5 clk = ~clk;

  fp_capture_ctrl #(.NUM_BINS(NUM_BINS), .BIN_W(BIN_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .capture_len(capture_len), .sample_tick(sample_tick), .mic_bit(mic_bit),
    .hist_addr(hist_addr), .hist_rd_en(hist_rd_en), .hist_wr_en(hist_wr_en),
    .hist_wr_data(hist_wr_data), .hist_rd_data(hist_rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done), .overrun_err(overrun_err)
  );

  // Histogram RAM model with registered read and a bench-side poke port.
  logic [BIN_W-1:0]  mem [2**ADDR_W];
  logic              poke_en = 1'b0;
  logic [ADDR_W-1:0] poke_addr = '0;
  logic [BIN_W-1:0]  poke_data = '0;
  int                wr_count = 0;

  always @(posedge clk) begin
    if (hist_rd_en) hist_rd_data <= mem[hist_addr];
    if (hist_wr_en) begin
      mem[hist_addr] <= hist_wr_data;
      wr_count <= wr_count + 1;
    end
    if (poke_en) mem[poke_addr] <= poke_data;
  end

  typedef struct packed {
    logic [BIN_W-1:0] data;
    logic             last;
  } beat_t;

  beat_t            exp_q[$];
  logic [BIN_W-1:0] exp_bins [NUM_BINS];
  int               checks = 0;
  int               errors = 0;

  // Monitor: pops one expected beat per accepted handshake and checks that a
  // stalled beat stays put until it is accepted.
  initial begin : monitor
    logic             held_valid;
    logic [BIN_W-1:0] held_data;
    logic             held_last;
    beat_t            b;
    int               beat_no;
    held_valid = 1'b0;
    held_data  = '0;
    held_last  = 1'b0;
    beat_no    = 0;
    forever begin
      @(negedge clk);
      if (rst_n && held_valid) begin
        checks++;
        if (!out_valid || out_data !== held_data || out_last !== held_last) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b data=%h last=%0b, required valid=1 data=%h last=%0b",
                   out_valid, out_data, out_last, held_data, held_last);
        end
      end
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got data=%h last=%0b, required no beat", out_data, out_last);
        end else begin
          b = exp_q.pop_front();
          if (out_data !== b.data || out_last !== b.last) begin
            errors++;
            $display("FAIL beat_%0d: got data=%h last=%0b, required data=%h last=%0b",
                     beat_no, out_data, out_last, b.data, b.last);
          end else begin
            $display("beat %0d data=%h last=%0b ok", beat_no, out_data, out_last);
          end
        end
        beat_no++;
      end
      held_valid = rst_n && out_valid && !out_ready;
      held_data  = out_data;
      held_last  = out_last;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < NUM_BINS; i++) exp_bins[i] = '0;
  endtask

  task automatic push_exp();
    beat_t b;
    for (int i = 0; i < NUM_BINS; i++) begin
      b.data = exp_bins[i];
      b.last = (i == NUM_BINS - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic do_start(input logic [19:0] len);
    @(posedge clk); #1;
    start = 1'b1;
    capture_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_clear();
    repeat (NUM_BINS + 2) @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic b);
    sample_tick = 1'b1;
    mic_bit = b;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    mic_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Drives out_ready until done is seen; optionally stalls one beat.
  task automatic drain(input int stall_beat, input int stall_len, output bit got_done);
    int beat;
    int stalled;
    beat = 0;
    stalled = 0;
    got_done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
      if (out_valid && beat == stall_beat && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) beat++;
      @(posedge clk); #1;
      if (done) got_done = 1'b1;
    end
    out_ready = 1'b0;
  endtask

  task automatic finish_session(input string name, input int stall_beat, input int stall_len);
    bit got_done;
    drain(stall_beat, stall_len, got_done);
    chk({name, "_done_seen"}, 32'(got_done), 32'd1);
    @(posedge clk); #1;
    chk({name, "_done_pulse_1cyc"}, 32'(done), 32'd0);
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    chk({name, "_beats_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : stim
    int wc;
    int acc;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_overrun", 32'(overrun_err), 32'd0);
    chk("rst_wr_en", 32'(hist_wr_en), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Ticks 1,1,0,1,0,0 -> bins 2,1,0 each 1; beat 3 stalled 10 cycles
    do_start(20'd6);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_clear();
    tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b0);
    clear_exp();
    exp_bins[0] = 20'd1;
    exp_bins[1] = 20'd1;
    exp_bins[2] = 20'd1;
    push_exp();
    finish_session("t1", 2, 10);
    chk("t1_overrun", 32'(overrun_err), 32'd0);

    // 60 ones then a zero: run counter saturates at the last bin
    do_start(20'd61);
    wait_clear();
    for (int i = 0; i < 60; i++) tick(1'b1);
    tick(1'b0);
    clear_exp();
    exp_bins[NUM_BINS-1] = 20'd1;
    push_exp();
    finish_session("t2", -1, 0);

    // Bin already at full scale stays there
    do_start(20'd1);
    wait_clear();
    poke_en = 1'b1;
    poke_addr = '0;
    poke_data = 20'hFFFFF;
    @(posedge clk); #1;
    poke_en = 1'b0;
    tick(1'b0);
    clear_exp();
    exp_bins[0] = 20'hFFFFF;
    push_exp();
    finish_session("t3", -1, 0);

    // Back-to-back ticks: second is dropped and flags overrun
    do_start(20'd3);
    wait_clear();
    sample_tick = 1'b1;
    mic_bit = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t4_overrun_set", 32'(overrun_err), 32'd1);
    tick(1'b1);
    tick(1'b0);
    clear_exp();
    exp_bins[0] = 20'd1;
    exp_bins[1] = 20'd1;
    push_exp();
    finish_session("t4", -1, 0);
    chk("t4_overrun_sticky", 32'(overrun_err), 32'd1);

    // Abort in CAPTURE on the RMW write cycle: no write, IDLE next cycle
    do_start(20'd10);
    chk("t5_overrun_cleared", 32'(overrun_err), 32'd0);
    wait_clear();
    tick(1'b1);
    sample_tick = 1'b1;
    mic_bit = 1'b0;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    abort = 1'b1;
    wc = wr_count;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t5_abort_busy", 32'(busy), 32'd0);
    chk("t5_abort_valid", 32'(out_valid), 32'd0);
    chk("t5_abort_wr_en", 32'(hist_wr_en), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("t5_abort_no_writes", 32'(wr_count - wc), 32'd0);
    chk("t5_abort_still_idle", 32'(busy), 32'd0);

    // Zero-length capture straight to readout, then reset during EMIT
    do_start(20'd0);
    clear_exp();
    for (int i = 0; i < 2; i++) exp_q.push_back('{data: '0, last: 1'b0});
    acc = 0;
    for (int cyc = 0; cyc < 300 && acc < 2; cyc++) begin
      out_ready = 1'b1;
      if (out_valid) acc++;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 10 && !out_valid; cyc++) begin
      @(posedge clk); #1;
    end
    chk("t6_emit_reached", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    wc = wr_count;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_rd_en", 32'(hist_rd_en), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_rst_no_writes", 32'(wr_count - wc), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_idle_after_rst", 32'(busy), 32'd0);
    chk("t6_beats_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_capture_ctrl.md
FP_CAPTURE_CTRL -- requirements
Module: fp_capture_ctrl

Interface
REQ-001 Parameter NUM_BINS, default 50, SHALL set the number of run-length histogram bins.
REQ-002 Parameter BIN_W, default 20, SHALL set the bin counter width.
REQ-003 Parameter ADDR_W, default 6, SHALL set the bin address width; NUM_BINS <= 2**ADDR_W.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  in  1  SHALL request a session when high in IDLE.
REQ-007 abort  in  1  SHALL force return to IDLE from any state.
REQ-008 capture_len  in  20  SHALL give the number of sample ticks per capture; latched on start.
REQ-009 sample_tick  in  1  SHALL be a one-cycle strobe marking a valid mic_bit.
REQ-010 mic_bit  in  1  SHALL be the 1-bit microphone sample.
REQ-011 hist_addr  out  ADDR_W  SHALL address the histogram RAM.
REQ-012 hist_rd_en / hist_wr_en  out  1 each  SHALL be the RAM read and write strobes.
REQ-013 hist_wr_data  out  BIN_W  SHALL be the RAM write data.
REQ-014 hist_rd_data  in  BIN_W  SHALL be valid exactly one cycle after hist_rd_en.
REQ-015 out_valid / out_data[BIN_W] / out_last  out  SHALL form the readout stream; out_ready  in  1  SHALL be its back-pressure.
REQ-016 busy, done, overrun_err  out  1 each  SHALL report status.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, CAPTURE, READ, EMIT, DONE.
REQ-018 IDLE->CLEAR on start=1; latch capture_len; clear overrun_err; capture_len=0 SHALL skip CAPTURE (CLEAR->READ).
REQ-019 CLEAR SHALL write 0 to addresses 0..NUM_BINS-1, one per cycle, then enter CAPTURE (NUM_BINS cycles).
REQ-020 CAPTURE: run counter run_cnt (reset 0) SHALL increment, saturating at NUM_BINS-1, on each tick with mic_bit=1.
REQ-021 CAPTURE: tick with mic_bit=0 SHALL start read-modify-write on bin run_cnt: cycle 0 hist_rd_en, cycle 1 hist_wr_en with hist_rd_data+1, and reset run_cnt to 0.
REQ-022 Bin increment SHALL saturate at 2**BIN_W-1 (no wrap).
REQ-023 A tick arriving during the RMW write cycle SHALL be dropped and set overrun_err (sticky until next start).
REQ-024 Every tick (0 or 1) SHALL decrement the remaining-tick counter; CAPTURE->READ after the tick bringing it to 0 and any RMW it triggers completes.
REQ-025 READ SHALL issue hist_rd_en for bin k (k from 0), then EMIT with out_valid=1, out_data=bin k.
REQ-026 EMIT SHALL hold out_valid/out_data/out_last stable until out_ready=1; on acceptance k+1 -> READ, or DONE if k=NUM_BINS-1.
REQ-027 out_last SHALL be 1 only with bin NUM_BINS-1.
REQ-028 DONE SHALL pulse done for one cycle then return to IDLE.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 sample_tick outside CAPTURE SHALL be ignored without error.
REQ-031 abort SHALL take priority over all transitions; next cycle IDLE, all strobes and out_valid 0, no further RAM writes.
REQ-032 start while busy SHALL be ignored.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE and zero all outputs, run_cnt, tick counter, and k.
REQ-034 Reset mid-session SHALL abandon it; RAM contents are not cleared until the next CLEAR.

Verification
REQ-035 Reset then start, capture_len=6, ticks 1,1,0,1,0,0 -> bins 2=1, 1=1, 0=1, rest 0; 50 beats out, out_last on beat 50, done pulse.
REQ-036 60 consecutive mic_bit=1 ticks then one 0 -> bin 49 =1 (saturation), bins 0..48 =0.
REQ-037 Preloaded bin 0 = 0xFFFFF, zero-clear bypassed by forcing RAM, tick 0 -> bin 0 stays 0xFFFFF.
REQ-038 Ticks on consecutive cycles -> overrun_err=1, dropped tick not counted.
REQ-039 out_ready low 10 cycles on beat 3 -> out_data/out_valid stable, no beat skipped or duplicated.
REQ-040 abort during CAPTURE, and rst_n low during EMIT -> IDLE next cycle, busy=0, out_valid=0, no further hist_wr_en.
